// File: rtl/sram_arbiter.sv
// ============================================================================
// Module      : sram_arbiter
// Description : Round-robin two-port arbiter and half-word sequencer that
//               maps 32-bit word reads/writes onto a shared 16-bit SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter #(
  parameter int PHASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_rd,
  input  logic        p0_wr,
  input  logic [16:0] p0_address,
  input  logic [31:0] p0_writedata,
  output logic [31:0] p0_readdata,
  output logic        p0_not_ready,
  input  logic        p1_rd,
  input  logic        p1_wr,
  input  logic [16:0] p1_address,
  input  logic [31:0] p1_writedata,
  output logic [31:0] p1_readdata,
  output logic        p1_not_ready,
  output logic [17:0] SRAMaddress,
  inout  wire  [15:0] SRAMdata,
  output logic        SRAMWEn,
  output logic        SRAMOEn
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] c_last   = 4'(PHASE_CYCLES - 1);
  localparam logic       c_single = (PHASE_CYCLES == 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_last_grant;
  logic        r_grant;
  logic        r_op_wr;
  logic [16:0] r_addr;
  logic [31:0] r_wdata;
  logic [15:0] r_rd_lo;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic        w_req0;
  logic        w_req1;
  logic        w_gnt_valid;
  logic        w_gnt_port;
  logic        w_phase_last;
  logic        w_active;
  logic        w_hi;
  logic        w_drive;
  logic [15:0] w_wr_half;

  assign w_req0       = p0_rd | p0_wr;
  assign w_req1       = p1_rd | p1_wr;
  assign w_gnt_valid  = w_req0 | w_req1;
  // On a tie the port that did not win last time goes next.
  assign w_gnt_port   = (w_req0 & w_req1) ? ~r_last_grant : w_req1;
  assign w_phase_last = (r_cnt == c_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_valid)  w_state_nxt = S_LO;
      S_LO:    if (w_phase_last) w_state_nxt = S_HI;
      S_HI:    if (w_phase_last) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= 4'd0;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_op_wr      <= 1'b0;
      r_addr       <= 17'd0;
      r_wdata      <= 32'd0;
      r_rd_lo      <= 16'd0;
      r_rdata0     <= 32'd0;
      r_rdata1     <= 32'd0;
    end else begin
      if (w_active) begin
        r_cnt <= w_phase_last ? 4'd0 : r_cnt + 4'd1;
      end else begin
        r_cnt <= 4'd0;
      end

      if ((r_state == S_IDLE) && w_gnt_valid) begin
        r_grant <= w_gnt_port;
        r_op_wr <= w_gnt_port ? p1_wr : p0_wr;
        r_addr  <= w_gnt_port ? p1_address : p0_address;
        r_wdata <= w_gnt_port ? p1_writedata : p0_writedata;
      end

      // Low half is staged so a port's readdata only changes on a finished read.
      if ((r_state == S_LO) && w_phase_last && !r_op_wr) begin
        r_rd_lo <= SRAMdata;
      end

      if ((r_state == S_HI) && w_phase_last && !r_op_wr) begin
        if (r_grant) begin
          r_rdata1 <= {SRAMdata, r_rd_lo};
        end else begin
          r_rdata0 <= {SRAMdata, r_rd_lo};
        end
      end

      if (r_state == S_DONE) begin
        r_last_grant <= r_grant;
      end
    end
  end

  assign w_active  = (r_state == S_LO) || (r_state == S_HI);
  assign w_hi      = (r_state == S_HI);
  assign w_drive   = w_active & r_op_wr;
  assign w_wr_half = w_hi ? r_wdata[31:16] : r_wdata[15:0];

  // Pins decode only registered state, never the request inputs.
  always_comb begin
    SRAMaddress = 18'd0;
    SRAMOEn     = 1'b1;
    SRAMWEn     = 1'b1;
    if (w_active) begin
      SRAMaddress = {r_addr, w_hi};
      SRAMOEn     = r_op_wr;
      SRAMWEn     = ~(r_op_wr & (c_single | ~w_phase_last));
    end
  end

  assign SRAMdata     = w_drive ? w_wr_half : 16'hzzzz;

  assign p0_readdata  = r_rdata0;
  assign p1_readdata  = r_rdata1;
  assign p0_not_ready = w_req0 & ~((r_state == S_DONE) & (r_grant == 1'b0));
  assign p1_not_ready = w_req1 & ~((r_state == S_DONE) & (r_grant == 1'b1));

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Directed self-checking bench for sram_arbiter, P=2 and P=1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

  logic clk;
  logic rst;

  // Instance with PHASE_CYCLES = 2
  logic        p0_rd, p0_wr, p1_rd, p1_wr;
  logic [16:0] p0_address, p1_address;
  logic [31:0] p0_writedata, p1_writedata;
  wire  [31:0] p0_readdata, p1_readdata;
  wire         p0_not_ready, p1_not_ready;
  wire  [17:0] saddr2;
  wire  [15:0] sdata2;
  wire         wen2, oen2;

  // Instance with PHASE_CYCLES = 1 (port 0 unused)
  logic        z_rd, z_wr;
  logic [16:0] z_address;
  logic [31:0] z_writedata;
  wire  [31:0] z_readdata;
  wire         z_not_ready;
  logic        q1_rd, q1_wr;
  logic [16:0] q1_address;
  logic [31:0] q1_writedata;
  wire  [31:0] q1_readdata;
  wire         q1_not_ready;
  wire  [17:0] saddr1;
  wire  [15:0] sdata1;
  wire         wen1, oen1;

  logic [15:0] mem2 [0:1023];
  logic [15:0] mem1 [0:1023];
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [15:0] pl_data;

  int n_tests;
  int n_fail;

  logic [31:0] rec_nr0, rec_nr1, rec_oen, rec_wen, rec_nrq, rec_oenq, rec_wenq;
  logic [17:0] rec_addr [0:31];

  sram_arbiter #(.PHASE_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst),
    .p0_rd(p0_rd), .p0_wr(p0_wr), .p0_address(p0_address),
    .p0_writedata(p0_writedata), .p0_readdata(p0_readdata), .p0_not_ready(p0_not_ready),
    .p1_rd(p1_rd), .p1_wr(p1_wr), .p1_address(p1_address),
    .p1_writedata(p1_writedata), .p1_readdata(p1_readdata), .p1_not_ready(p1_not_ready),
    .SRAMaddress(saddr2), .SRAMdata(sdata2), .SRAMWEn(wen2), .SRAMOEn(oen2)
  );

  sram_arbiter #(.PHASE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .p0_rd(z_rd), .p0_wr(z_wr), .p0_address(z_address),
    .p0_writedata(z_writedata), .p0_readdata(z_readdata), .p0_not_ready(z_not_ready),
    .p1_rd(q1_rd), .p1_wr(q1_wr), .p1_address(q1_address),
    .p1_writedata(q1_writedata), .p1_readdata(q1_readdata), .p1_not_ready(q1_not_ready),
    .SRAMaddress(saddr1), .SRAMdata(sdata1), .SRAMWEn(wen1), .SRAMOEn(oen1)
  );

  // Asynchronous-read SRAM models; writes land on the clock edge.
  always @(posedge clk) begin
    if (pl_en) mem2[pl_addr] <= pl_data;
    else if (!wen2) mem2[saddr2[9:0]] <= sdata2;
  end
  assign sdata2 = (!oen2 && wen2) ? mem2[saddr2[9:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!wen1) mem1[saddr1[9:0]] <= sdata1;
  end
  assign sdata1 = (!oen1 && wen1) ? mem1[saddr1[9:0]] : 16'hzzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    p0_rd = 1'b0; p0_wr = 1'b0; p1_rd = 1'b0; p1_wr = 1'b0;
    q1_rd = 1'b0; q1_wr = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Sample cycles start..start+n-1 on the falling edge.
  task automatic run(input int start, input int n);
    for (int i = start; i < start + n; i++) begin
      @(negedge clk);
      rec_nr0[i]  = p0_not_ready;
      rec_nr1[i]  = p1_not_ready;
      rec_oen[i]  = oen2;
      rec_wen[i]  = wen2;
      rec_addr[i] = saddr2;
      rec_nrq[i]  = q1_not_ready;
      rec_oenq[i] = oen1;
      rec_wenq[i] = wen1;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    p0_rd = 1'b0; p0_wr = 1'b0; p0_address = '0; p0_writedata = '0;
    p1_rd = 1'b0; p1_wr = 1'b0; p1_address = '0; p1_writedata = '0;
    z_rd = 1'b0; z_wr = 1'b0; z_address = '0; z_writedata = '0;
    q1_rd = 1'b0; q1_wr = 1'b0; q1_address = '0; q1_writedata = '0;

    preload(10'h20A, 16'h5678);
    preload(10'h20B, 16'h1234);
    preload(10'h006, 16'hAAAA);
    preload(10'h007, 16'h5555);
    do_reset();

    check("rst_addr", {14'd0, saddr2}, 32'd0);
    check("rst_wen", {31'd0, wen2}, 32'd1);
    check("rst_oen", {31'd0, oen2}, 32'd1);
    check("rst_rdata0", p0_readdata, 32'd0);
    check("rst_rdata1", p1_readdata, 32'd0);
    check("rst_p1_pins", {30'd0, wen1, oen1}, 32'd3);

    // Single read, P=2
    p0_rd = 1'b1; p0_address = 17'h00105;
    run(0, 6);
    check("rd_not_ready", rec_nr0[5:0], 32'b011111);
    check("rd_oen", rec_oen[5:0], 32'b100001);
    check("rd_addr_lo", {14'd0, rec_addr[1]}, 32'h20A);
    check("rd_addr_hi", {14'd0, rec_addr[3]}, 32'h20B);
    check("rd_data", p0_readdata, 32'h12345678);
    p0_rd = 1'b0;

    // Write then read, P=1
    q1_wr = 1'b1; q1_address = 17'h00003; q1_writedata = 32'hDEADBEEF;
    run(0, 4);
    check("p1w_wen", rec_wenq[3:0], 32'b1001);
    check("p1w_not_ready", rec_nrq[3:0], 32'b0111);
    q1_wr = 1'b0; q1_rd = 1'b1;
    run(0, 4);
    check("p1r_not_ready", rec_nrq[3:0], 32'b0111);
    check("p1r_oen", rec_oenq[3:0], 32'b1001);
    check("p1r_data", q1_readdata, 32'hDEADBEEF);
    check("p1w_mem_lo", {16'd0, mem1[6]}, 32'hBEEF);
    check("p1w_mem_hi", {16'd0, mem1[7]}, 32'hDEAD);
    q1_rd = 1'b0;

    // Simultaneous requests from reset
    do_reset();
    p0_rd = 1'b1; p0_address = 17'h00105;
    p1_rd = 1'b1; p1_address = 17'h00003;
    run(0, 24);
    check("tie_nr0", rec_nr0[23:0], 32'hFDFFDF);
    check("tie_nr1", rec_nr1[23:0], 32'h7FF7FF);
    check("tie_rdata0", p0_readdata, 32'h12345678);
    check("tie_rdata1", p1_readdata, 32'h5555AAAA);
    p0_rd = 1'b0; p1_rd = 1'b0;

    // Request dropped mid-write
    do_reset();
    p0_wr = 1'b1; p0_address = 17'h00010; p0_writedata = 32'hCAFEF00D;
    run(0, 3);
    p0_wr = 1'b0;
    run(3, 5);
    check("drop_not_ready", rec_nr0[7:0], 32'b00000111);
    check("drop_wen", rec_wen[7:0], 32'b11110101);
    check("drop_idle_addr", {14'd0, rec_addr[7]}, 32'd0);
    check("drop_mem_lo", {16'd0, mem2[10'h020]}, 32'hF00D);
    check("drop_mem_hi", {16'd0, mem2[10'h021]}, 32'hCAFE);

    // Reset during LO of a write; last grant was port 0 beforehand
    p1_wr = 1'b1; p1_address = 17'h00004; p1_writedata = 32'h11112222;
    run(0, 1);
    rst = 1'b1;
    run(1, 1);
    rst = 1'b0; p1_wr = 1'b0;
    run(2, 1);
    check("mrst_wen_lo", {31'd0, rec_wen[1]}, 32'd0);
    check("mrst_pins", {rec_addr[2], rec_wen[2], rec_oen[2]}, 32'd3);
    p0_rd = 1'b1; p0_address = 17'h00105;
    p1_rd = 1'b1; p1_address = 17'h00003;
    run(0, 6);
    check("mrst_tie_nr0", rec_nr0[5:0], 32'b011111);
    check("mrst_tie_nr1", rec_nr1[5:0], 32'b111111);
    check("mrst_rdata0", p0_readdata, 32'h12345678);
    p0_rd = 1'b0; p1_rd = 1'b0;

    // rd and wr together: performed as a write
    p0_rd = 1'b1; p0_wr = 1'b1; p0_address = 17'h00030; p0_writedata = 32'h0BADCAFE;
    run(0, 6);
    check("rdwr_oen", rec_oen[5:0], 32'b111111);
    check("rdwr_wen", rec_wen[5:0], 32'b110101);
    check("rdwr_mem_lo", {16'd0, mem2[10'h060]}, 32'hCAFE);
    check("rdwr_mem_hi", {16'd0, mem2[10'h061]}, 32'h0BAD);
    check("rdwr_rdata0", p0_readdata, 32'h12345678);
    p0_rd = 1'b0; p0_wr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
